// File: rtl/cmp_pkg.sv
// cmp_pkg: shared state encoding and default sizing for the compare-sharing arbiter
package cmp_pkg;
   localparam int NREQ_D = 4;
   localparam int W_D = 4;
   localparam int ID_W = $clog2(NREQ_D);
   typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, RESP = 2'd2} state_t;
endpackage

// File: rtl/cmp_core.sv
// cmp_core: combinational unsigned magnitude comparator
module cmp_core #(
   parameter int W = 4
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         eq,
   output logic         lt,
   output logic         gt
);
   assign eq = a == b;
   assign lt = a < b;
   assign gt = a > b;
endmodule

// File: rtl/cmp_share_arbiter.sv
// cmp_share_arbiter: round-robin share of one comparator among NREQ requesters
module cmp_share_arbiter
   import cmp_pkg::*;
#(
   parameter int NREQ = NREQ_D,
   parameter int W = W_D,
   localparam int IW = $clog2(NREQ)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NREQ-1:0] req,
   input  logic [NREQ*W-1:0] a_in,
   input  logic [NREQ*W-1:0] b_in,
   output logic [NREQ-1:0] gnt,
   output logic            busy,
   output logic            rsp_valid,
   output logic [IW-1:0]   rsp_id,
   output logic            rsp_equal,
   output logic            rsp_lesser,
   output logic            rsp_greater
);
   state_t        state;
   logic [IW-1:0] ptr, pick, id;
   logic [W-1:0]  opa, opb;
   logic          eq, lt, gt;
   int            j;

   // descending scan so the lowest offset from ptr wins
   always_comb begin
      pick = '0;
      j = 0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         j = int'(ptr) + i;
         j = j >= NREQ ? j - NREQ : j;
         if (req[j]) pick = IW'(j);
      end
   end

   cmp_core #(.W(W)) u_core (.a(opa), .b(opb), .eq(eq), .lt(lt), .gt(gt));

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         ptr <= '0;
         id <= '0;
         opa <= '0;
         opb <= '0;
         gnt <= '0;
         busy <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_id <= '0;
         {rsp_equal, rsp_lesser, rsp_greater} <= 3'b000;
      end else begin
         case (state)
            IDLE: if (|req) begin
               gnt <= NREQ'(1) << pick;
               opa <= a_in[int'(pick)*W +: W];
               opb <= b_in[int'(pick)*W +: W];
               id <= pick;
               ptr <= pick == IW'(NREQ - 1) ? '0 : pick + 1'b1;
               busy <= 1'b1;
               state <= GRANT;
            end
            GRANT: begin
               gnt <= '0;
               rsp_valid <= 1'b1;
               rsp_id <= id;
               {rsp_equal, rsp_lesser, rsp_greater} <= {eq, lt, gt};
               state <= RESP;
            end
            default: begin
               gnt <= '0;
               busy <= 1'b0;
               rsp_valid <= 1'b0;
               rsp_id <= '0;
               {rsp_equal, rsp_lesser, rsp_greater} <= 3'b000;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_cmp_share_arbiter.sv
// tb_cmp_share_arbiter: directed self-checking bench for cmp_share_arbiter
module tb_cmp_share_arbiter;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  req = '0;
   logic [15:0] a_in = '0, b_in = '0;
   logic [3:0]  gnt;
   logic        busy, rsp_valid, rsp_equal, rsp_lesser, rsp_greater;
   logic [1:0]  rsp_id;
   int          n_cmp = 0, n_bad = 0;

   cmp_share_arbiter dut (
      .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
      .gnt(gnt), .busy(busy), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
      .rsp_equal(rsp_equal), .rsp_lesser(rsp_lesser), .rsp_greater(rsp_greater)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // one arbitration from IDLE; flags = {eq,lt,gt}; scramble alters operands after the grant
   task automatic txn(input logic [3:0] r, input int id, input logic [2:0] flags,
                      input bit keep, input bit scramble);
      req = r;
      tick();
      check("gnt", gnt, 1 << id);
      check("busy_g", busy, 1);
      check("rv_g", rsp_valid, 0);
      if (!keep) req = '0;
      if (scramble) begin
         a_in = ~a_in;
         b_in = b_in + 16'h1357;
      end
      tick();
      check("rv", rsp_valid, 1);
      check("rsp_id", rsp_id, id);
      check("flags", {rsp_equal, rsp_lesser, rsp_greater}, flags);
      check("gnt_r", gnt, 0);
      tick();
      check("rv_i", rsp_valid, 0);
      check("flags_i", {rsp_equal, rsp_lesser, rsp_greater}, 0);
      check("busy_i", busy, 0);
   endtask

   initial begin
      req = 4'b1111;
      for (int i = 0; i < 2; i++) begin
         tick();
         check("rst_gnt", gnt, 0);
         check("rst_busy", busy, 0);
         check("rst_rv", rsp_valid, 0);
      end
      rst = 1'b0;
      req = '0;
      a_in[11:8] = 4'd9;
      b_in[11:8] = 4'd2;
      txn(4'b0100, 2, 3'b001, 0, 0);

      rst = 1'b1;
      tick();
      rst = 1'b0;
      a_in = 16'h5555;
      b_in = 16'h5555;
      for (int i = 0; i < 8; i++) txn(4'b1111, i % 4, 3'b100, 1, 0);

      txn(4'b1001, 0, 3'b100, 1, 0);
      txn(4'b1001, 3, 3'b100, 0, 0);

      for (int a = 0; a < 16; a++)
         for (int b = 0; b < 16; b++) begin
            a_in = '0;
            b_in = '0;
            a_in[7:4] = 4'(a);
            b_in[7:4] = 4'(b);
            txn(4'b0010, 1, {a == b, a < b, a > b}, 0, 1);
         end

      a_in = 16'h0300;
      b_in = 16'h0a00;
      txn(4'b0101, 2, 3'b010, 0, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("drop_gnt", gnt, 0);
         check("drop_busy", busy, 0);
      end

      req = 4'b0100;
      tick();
      check("g_pre_rst", gnt, 4'b0100);
      req = '0;
      rst = 1'b1;
      tick();
      check("rst_g_rv", rsp_valid, 0);
      check("rst_g_gnt", gnt, 0);
      check("rst_g_busy", busy, 0);
      rst = 1'b0;
      tick();
      check("post_rst_rv", rsp_valid, 0);
      a_in = 16'h0007;
      b_in = 16'h0007;
      txn(4'b1111, 0, 3'b100, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
